// File: rtl/mc_ctrl_hs.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_hs
// Purpose  : Multicycle MIPS main controller with memory ready handshake,
//            bounded wait timeout and illegal-opcode trap. Optional jal path
//            enabled by defining MC_CTRL_JAL_EN.
// Revision : 1.0
// ============================================================================
module mc_ctrl_hs #(
    parameter int ALUOP_W  = 3,
    parameter int ST_W     = 6,
    parameter int MAX_WAIT = 15
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic               mem_rdy,
    output logic               mem_req,
    output logic               IDSel,
    output logic               MWE,
    output logic               IRWE,
    output logic               RFDSel,
    output logic               MtoRFSel,
    output logic               RFWE,
    output logic               ALUIn1Sel,
    output logic               PCWE,
    output logic               Branch,
    output logic               BranchNe,
    output logic               ZeroExt,
    output logic               LinkSel,
    output logic [1:0]         ALUIn2Sel,
    output logic [1:0]         PCSel,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               exc,
    output logic [ST_W-1:0]    st
);

    localparam int               c_CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(MAX_WAIT);

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_BNE  = 6'b000101;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_ANDI = 6'b001100;
    localparam logic [5:0] c_OP_ORI  = 6'b001101;
    localparam logic [5:0] c_OP_SLTI = 6'b001010;
`ifdef MC_CTRL_JAL_EN
    localparam logic [5:0] c_OP_JAL  = 6'b000011;
`endif

    localparam logic [2:0] c_ALU_ADD   = 3'd0;
    localparam logic [2:0] c_ALU_SUB   = 3'd1;
    localparam logic [2:0] c_ALU_FUNCT = 3'd2;
    localparam logic [2:0] c_ALU_AND   = 3'd3;
    localparam logic [2:0] c_ALU_OR    = 3'd4;
    localparam logic [2:0] c_ALU_SLT   = 3'd5;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB    = 4'd11,
        S_JAL    = 4'd12, S_TRAP   = 4'd13
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [5:0]          r_op_q;
    logic [c_CNT_W-1:0]  r_wait;
    logic                w_mem_state;
    logic                w_timeout;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // A ready on the final allowed cycle still completes the access.
    assign w_timeout   = w_mem_state && !mem_rdy && (r_wait == c_WAIT_MAX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_rdy) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_OP_R:                                      w_next = S_EXEC;
                    c_OP_LW, c_OP_SW:                            w_next = S_MEMADR;
                    c_OP_BEQ, c_OP_BNE:                          w_next = S_BRANCH;
                    c_OP_J:                                      w_next = S_JUMP;
                    c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_SLTI:   w_next = S_IEXEC;
`ifdef MC_CTRL_JAL_EN
                    c_OP_JAL:                                    w_next = S_JAL;
`endif
                    default:                                     w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (r_op_q == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_rdy) w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (mem_rdy) w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_IEXEC:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
`ifdef MC_CTRL_JAL_EN
            S_JAL:    w_next = S_FETCH;
`endif
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_TRAP;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op_q  <= 6'd0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op_q <= op;
            // Any state change clears the count, so each memory state starts fresh.
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_mem_state && !mem_rdy)
                r_wait <= r_wait + c_CNT_W'(1);
        end
    end

    always_comb begin
        mem_req   = 1'b0;  IDSel    = 1'b0;  MWE       = 1'b0;  IRWE  = 1'b0;
        RFDSel    = 1'b0;  MtoRFSel = 1'b0;  RFWE      = 1'b0;  PCWE  = 1'b0;
        ALUIn1Sel = 1'b0;  Branch   = 1'b0;  BranchNe  = 1'b0;  ZeroExt = 1'b0;
        LinkSel   = 1'b0;  ALUIn2Sel = 2'b00; PCSel    = 2'b00;
        ALUop     = ALUOP_W'(c_ALU_ADD);
        exc       = 1'b0;
        st        = '0;
        if (!rst) begin
            st = ST_W'(r_state);
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1; ALUIn2Sel = 2'b01; IRWE = mem_rdy; PCWE = mem_rdy;
                end
                S_DECODE: ALUIn2Sel = 2'b11;
                S_MEMADR: begin ALUIn1Sel = 1'b1; ALUIn2Sel = 2'b10; end
                S_MEMRD:  begin mem_req = 1'b1; IDSel = 1'b1; end
                S_MEMWB:  begin MtoRFSel = 1'b1; RFWE = 1'b1; end
                S_MEMWR:  begin mem_req = 1'b1; IDSel = 1'b1; MWE = 1'b1; end
                S_EXEC:   begin ALUIn1Sel = 1'b1; ALUop = ALUOP_W'(c_ALU_FUNCT); end
                S_ALUWB:  begin RFDSel = 1'b1; RFWE = 1'b1; end
                S_BRANCH: begin
                    ALUIn1Sel = 1'b1; ALUop = ALUOP_W'(c_ALU_SUB); PCSel = 2'b01;
                    Branch    = (r_op_q == c_OP_BEQ);
                    BranchNe  = (r_op_q == c_OP_BNE);
                end
                S_JUMP:   begin PCSel = 2'b10; PCWE = 1'b1; end
                S_IEXEC: begin
                    ALUIn1Sel = 1'b1; ALUIn2Sel = 2'b10;
                    case (r_op_q)
                        c_OP_ANDI: begin ALUop = ALUOP_W'(c_ALU_AND); ZeroExt = 1'b1; end
                        c_OP_ORI:  begin ALUop = ALUOP_W'(c_ALU_OR);  ZeroExt = 1'b1; end
                        c_OP_SLTI: ALUop = ALUOP_W'(c_ALU_SLT);
                        default:   ALUop = ALUOP_W'(c_ALU_ADD);
                    endcase
                end
                S_IWB:    RFWE = 1'b1;
`ifdef MC_CTRL_JAL_EN
                S_JAL:    begin PCSel = 2'b10; PCWE = 1'b1; RFWE = 1'b1; LinkSel = 1'b1; end
`endif
                S_TRAP:   exc = 1'b1;
                default:  ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_hs
// Purpose  : Self-checking bench for mc_ctrl_hs: instruction-path reference
//            model compared every cycle, plus directed literal checks.
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl_hs;

    localparam int c_MAX_WAIT = 4;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic       mem_rdy = 1'b1;
    logic       mem_req, IDSel, MWE, IRWE, RFDSel, MtoRFSel, RFWE, ALUIn1Sel, PCWE;
    logic       Branch, BranchNe, ZeroExt, LinkSel, exc;
    logic [1:0] ALUIn2Sel, PCSel;
    logic [2:0] ALUop;
    logic [5:0] st;

    mc_ctrl_hs #(.ALUOP_W(3), .ST_W(6), .MAX_WAIT(c_MAX_WAIT)) dut (
        .CLK(CLK), .rst(rst), .op(op), .mem_rdy(mem_rdy), .mem_req(mem_req),
        .IDSel(IDSel), .MWE(MWE), .IRWE(IRWE), .RFDSel(RFDSel), .MtoRFSel(MtoRFSel),
        .RFWE(RFWE), .ALUIn1Sel(ALUIn1Sel), .PCWE(PCWE), .Branch(Branch),
        .BranchNe(BranchNe), .ZeroExt(ZeroExt), .LinkSel(LinkSel),
        .ALUIn2Sel(ALUIn2Sel), .PCSel(PCSel), .ALUop(ALUop), .exc(exc), .st(st)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic mem_req, IDSel, MWE, IRWE, RFDSel, MtoRFSel, RFWE, ALUIn1Sel, PCWE;
        logic Branch, BranchNe, ZeroExt, LinkSel;
        logic [1:0] ALUIn2Sel, PCSel;
        logic [2:0] ALUop;
        logic exc;
        logic [5:0] st;
    } outs_t;

    outs_t got;
    assign got = {mem_req, IDSel, MWE, IRWE, RFDSel, MtoRFSel, RFWE, ALUIn1Sel, PCWE,
                  Branch, BranchNe, ZeroExt, LinkSel, ALUIn2Sel, PCSel, ALUop, exc, st};

    int n_vec = 0;
    int n_err = 0;

    // Sequence of state codes an opcode walks through, -1 terminated.
    function automatic int path_at(input logic [5:0] o, input int i);
        int p[5];
        case (o)
            6'b000000:                               p = '{0, 1, 6, 7, -1};
            6'b100011:                               p = '{0, 1, 2, 3, 4};
            6'b101011:                               p = '{0, 1, 2, 5, -1};
            6'b000100, 6'b000101:                    p = '{0, 1, 8, -1, -1};
            6'b000010:                               p = '{0, 1, 9, -1, -1};
            6'b001000, 6'b001100, 6'b001101, 6'b001010: p = '{0, 1, 10, 11, -1};
`ifdef MC_CTRL_JAL_EN
            6'b000011:                               p = '{0, 1, 12, -1, -1};
`endif
            default:                                 p = '{0, 1, 13, -1, -1};
        endcase
        return (i >= 0 && i < 5) ? p[i] : -1;
    endfunction

    function automatic outs_t exp_out(input int s, input logic [5:0] o, input logic rdy, input logic r);
        outs_t e = '0;
        if (r) return e;
        e.st = 6'(s);
        case (s)
            0:  begin e.mem_req = 1; e.ALUIn2Sel = 2'd1; e.IRWE = rdy; e.PCWE = rdy; end
            1:  e.ALUIn2Sel = 2'd3;
            2:  begin e.ALUIn1Sel = 1; e.ALUIn2Sel = 2'd2; end
            3:  begin e.mem_req = 1; e.IDSel = 1; end
            4:  begin e.MtoRFSel = 1; e.RFWE = 1; end
            5:  begin e.mem_req = 1; e.IDSel = 1; e.MWE = 1; end
            6:  begin e.ALUIn1Sel = 1; e.ALUop = 3'd2; end
            7:  begin e.RFDSel = 1; e.RFWE = 1; end
            8:  begin e.ALUIn1Sel = 1; e.ALUop = 3'd1; e.PCSel = 2'd1;
                      e.Branch = (o == 6'b000100); e.BranchNe = (o == 6'b000101); end
            9:  begin e.PCSel = 2'd2; e.PCWE = 1; end
            10: begin e.ALUIn1Sel = 1; e.ALUIn2Sel = 2'd2;
                      e.ALUop   = (o == 6'b001100) ? 3'd3 : (o == 6'b001101) ? 3'd4 :
                                  (o == 6'b001010) ? 3'd5 : 3'd0;
                      e.ZeroExt = (o == 6'b001100) || (o == 6'b001101); end
            11: e.RFWE = 1;
            12: begin e.PCSel = 2'd2; e.PCWE = 1; e.RFWE = 1; e.LinkSel = 1; end
            13: e.exc = 1;
            default: ;
        endcase
        return e;
    endfunction

    // Reference model: position within the opcode's path, stall count, trap flag.
    int         m_idx  = 0;
    int         m_wait = 0;
    logic [5:0] m_op   = 6'd0;
    logic       m_trap = 1'b0;

    always @(negedge CLK) begin
        int    s;
        int    nx;
        outs_t e;
        s = m_trap ? 13 : path_at(m_op, m_idx);
        e = exp_out(s, m_op, mem_rdy, rst);
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL cycle_outputs t=%0t: got st=%0d bundle=%h, expected st=%0d bundle=%h",
                     $time, got.st, got, e.st, e);
        end
        // Inputs seen now are the ones the DUT samples at the next rising edge.
        if (rst) begin
            m_idx = 0; m_wait = 0; m_op = 6'd0; m_trap = 1'b0;
        end else if (!m_trap) begin
            if ((s == 0 || s == 3 || s == 5) && !mem_rdy) begin
                if (m_wait == c_MAX_WAIT) begin m_trap = 1'b1; m_wait = 0; end
                else m_wait++;
            end else begin
                if (s == 1) m_op = op;
                nx = path_at(m_op, m_idx + 1);
                m_idx = (nx < 0) ? 0 : m_idx + 1;
                m_wait = 0;
                if (nx == 13) m_trap = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] x);
        n_vec++;
        if (g !== x) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, g, x);
        end
    endtask

    task automatic step(input logic [5:0] o, input logic r, input int xst, input string nm);
        @(posedge CLK); #1;
        op = o; mem_rdy = r;
        @(negedge CLK);
        chk(nm, 32'(st), 32'(xst));
    endtask

    task automatic do_reset();
        @(posedge CLK); #1; rst = 1'b1; op = 6'd0; mem_rdy = 1'b1;
        @(negedge CLK);
        chk("reset_outputs_zero", 32'(got), 32'd0);
        @(posedge CLK); #1; rst = 1'b0;
        @(negedge CLK);
        chk("after_reset_st", 32'(st), 32'd0);
    endtask

    int seq_st[5]   = '{0, 1, 6, 7, 0};
    int seq_rfwe[5] = '{0, 0, 0, 1, 0};
    logic [5:0] legal[10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                              6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

    initial begin
        int stall;
        int trap_cyc;
        // Reset held over two sampled cycles, then an R-type instruction.
        @(negedge CLK); chk("rst_cyc0_zero", 32'(got), 32'd0);
        @(negedge CLK); chk("rst_cyc1_zero", 32'(got), 32'd0);
        @(posedge CLK); #1; rst = 1'b0;
        @(negedge CLK);
        chk("r_st0", 32'(st), 32'(seq_st[0]));
        for (int i = 1; i < 5; i++) begin
            step(6'b000000, 1'b1, seq_st[i], "r_st");
            chk("r_rfwe", 32'(RFWE), 32'(seq_rfwe[i]));
        end

        // lw with three not-ready cycles in MEMRD.
        step(6'b100011, 1'b1, 1, "lw_decode");
        step(6'b100011, 1'b1, 2, "lw_memadr");
        for (int i = 0; i < 4; i++) begin
            step(6'b100011, (i == 3), 3, "lw_memrd");
            chk("lw_memrd_req", 32'({mem_req, IDSel}), 32'd3);
        end
        step(6'b000000, 1'b1, 4, "lw_memwb");
        chk("lw_memwb_rfwe", 32'(RFWE), 32'd1);

        // Memory never ready during FETCH: five fetch cycles then TRAP.
        for (int i = 0; i < 5; i++) begin
            step(6'b000000, 1'b0, 0, "to_fetch_st");
            chk("to_fetch_irwe", 32'(IRWE), 32'd0);
        end
        step(6'b000000, 1'b0, 13, "to_trap_st");
        chk("to_trap_exc", 32'(exc), 32'd1);
        step(6'b000000, 1'b1, 13, "trap_sticky_st");
        chk("trap_sticky_exc", 32'(exc), 32'd1);
        do_reset();
        chk("reset_clears_exc", 32'(exc), 32'd0);

        // bne, opcode changed mid-instruction, then andi.
        step(6'b000101, 1'b1, 1, "bne_decode");
        step(6'b000100, 1'b1, 8, "bne_branch");
        chk("bne_ctl", 32'({Branch, BranchNe, ALUop, PCSel}), 32'b0_1_001_01);
        step(6'b000100, 1'b1, 0, "bne_fetch");
        step(6'b001100, 1'b1, 1, "andi_decode");
        step(6'b001100, 1'b1, 10, "andi_iexec");
        chk("andi_ctl", 32'({ALUop, ZeroExt}), 32'b011_1);
        step(6'b001100, 1'b1, 11, "andi_iwb");
        chk("andi_wb", 32'({RFWE, RFDSel}), 32'b10);
        step(6'b000011, 1'b1, 0, "jal_fetch");
        step(6'b000011, 1'b1, 1, "jal_decode");
`ifdef MC_CTRL_JAL_EN
        step(6'b000011, 1'b1, 12, "jal_state");
        chk("jal_ctl", 32'({LinkSel, PCWE, RFWE, PCSel}), 32'b1_1_1_10);
`else
        step(6'b000011, 1'b1, 13, "jal_trap_state");
        chk("jal_trap_exc", 32'({exc, LinkSel}), 32'b10);
`endif
        do_reset();

        // Randomized traffic; the per-cycle compare process does the checking.
        stall = 0;
        trap_cyc = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge CLK); #1;
            trap_cyc = m_trap ? trap_cyc + 1 : 0;
            rst = (trap_cyc > 3) || ($urandom_range(0, 299) == 0);
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal[$urandom_range(0, 9)];
            if (stall > 0) begin
                mem_rdy = 1'b0;
                stall--;
            end else begin
                mem_rdy = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 39) == 0) stall = $urandom_range(2, 7);
            end
        end
        @(posedge CLK); #1; rst = 1'b0;
        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl_hs.md
# mc_ctrl_hs

Parametrised multicycle MIPS main controller, successor to the fixed 12-state controller. Registered state machine that drives datapath selects and write enables per instruction phase. Adds a memory request/ready handshake with a bounded wait timeout, bne/andi/ori/slti support, an illegal-opcode trap, and an optional jal path. Sits between the instruction register opcode field and the multicycle datapath/memory port.

## Interface
- ALUOP_W, 3, ALUop width (≥3)
- ST_W, 6, width of debug state output `st` (≥4)
- MAX_WAIT, 15, maximum consecutive mem_rdy-low cycles tolerated in a memory state (1..255)

- CLK  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- op  in  6  opcode from IR
- mem_rdy  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- IDSel, MWE, IRWE, RFDSel, MtoRFSel, RFWE, ALUIn1Sel, PCWE  out  1 each  datapath controls (same meaning as predecessor)
- Branch, BranchNe  out  1 each  PC write when Zero=1 / Zero=0
- ZeroExt  out  1  immediate zero-extend (else sign-extend)
- LinkSel  out  1  RF write address=31, data=PC
- ALUIn2Sel, PCSel  out  2 each  00 B / 01 const 4 / 10 imm / 11 imm<<2; PC: 00 ALU / 01 ALUOut / 10 jump target
- ALUop  out  ALUOP_W  0 add, 1 sub, 2 funct, 3 and, 4 or, 5 slt
- exc  out  1  trap flag, sticky until reset
- st  out  ST_W  current state code, zero-extended

## Operation
- States (code): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, JAL 12, TRAP 13.
- Moore outputs decoded from state register; IRWE/PCWE in FETCH additionally qualified by mem_rdy. Every output not listed for a state is 0 (no X).
- FETCH: mem_req=1, IDSel=0, ALUIn1Sel=0, ALUIn2Sel=01, ALUop=add, PCSel=00, IRWE=PCWE=mem_rdy. → DECODE on mem_rdy.
- DECODE: latch op into internal op_q; ALUIn1Sel=0, ALUIn2Sel=11, ALUop=add. Next by op: 000000→EXEC; 100011/101011→MEMADR; 000100/000101→BRANCH; 000010→JUMP; 001000/001100/001101/001010→IEXEC; 000011→JAL (macro only); else→TRAP. Later states use op_q only.
- MEMADR: ALUIn1Sel=1, ALUIn2Sel=10, add. lw→MEMRD, sw→MEMWR.
- MEMRD: mem_req=1, IDSel=1; →MEMWB on mem_rdy. MEMWB: RFDSel=0, MtoRFSel=1, RFWE=1 →FETCH.
- MEMWR: mem_req=1, IDSel=1, MWE=1; →FETCH on mem_rdy.
- EXEC: ALUIn1Sel=1, ALUIn2Sel=00, ALUop=funct →ALUWB. ALUWB: RFDSel=1, RFWE=1 →FETCH.
- BRANCH: ALUIn1Sel=1, ALUIn2Sel=00, sub, PCSel=01, Branch=(beq), BranchNe=(bne) →FETCH.
- JUMP: PCSel=10, PCWE=1 →FETCH.
- IEXEC: ALUIn1Sel=1, ALUIn2Sel=10; addi add, andi and+ZeroExt, ori or+ZeroExt, slti slt →IWB. IWB: RFDSel=0, MtoRFSel=0, RFWE=1 →FETCH.
- TRAP: exc=1, all else 0; remains until rst.
- Wait counter (width clog2(MAX_WAIT+1)): cleared on entry to FETCH/MEMRD/MEMWR, increments each cycle in those states with mem_rdy=0; on the cycle it equals MAX_WAIT with mem_rdy=0, next state TRAP. mem_rdy=1 on that same cycle wins (normal advance).
- mem_rdy outside memory states is ignored.

## Timing
- rst high: state←FETCH, op_q←0, counter←0; while rst high all outputs forced 0 and st=0. Reset mid-instruction abandons it; no write enable asserts during or in the cycle of reset.
- Zero-wait latency (cycles FETCH→next FETCH): R 4, lw 5, sw 4, beq/bne 3, j 3, I-type 4, jal 3. Each memory state adds one cycle per mem_rdy-low cycle.
- Write enables are single-cycle pulses per instruction except MWE (held through MEMWR wait).

## Configuration
- MC_CTRL_JAL_EN defined: opcode 000011 →JAL state: PCSel=10, PCWE=1, RFWE=1, LinkSel=1 →FETCH.
- Undefined: JAL state absent, 000011 →TRAP, LinkSel tied 0.

## Test plan
- rst 1 for 2 cycles, op=000000, mem_rdy=1 → all outputs 0 during reset; then st=0,1,6,7,0 with RFWE=1 only at st=7.
- lw with mem_rdy low 3 cycles in MEMRD → MEMRD held 4 cycles, mem_req=1, IDSel=1 throughout, RFWE=1 one cycle at MEMWB; total 8 cycles.
- MAX_WAIT=4, mem_rdy stuck 0 in FETCH → TRAP after 5 cycles, exc=1 held, IRWE never 1; rst clears exc.
- bne (000101) → BRANCH with BranchNe=1, Branch=0, ALUop=1, PCSel=01; op changed to 000100 mid-instruction does not alter outputs.
- andi (001100) → IEXEC ALUop=3, ZeroExt=1; then IWB RFWE=1, RFDSel=0.
- op=000011: with MC_CTRL_JAL_EN → st=12, LinkSel=1, PCWE=1, RFWE=1; without → st=13, exc=1.
